bht_ctrl: RTL and testbench
===========================

BHT_CTRL -- requirements
Module: bht_ctrl

Interface
REQ-001 The block SHALL have one parameter: IDX_W, default 4, table index width; the table holds 2^IDX_W two-bit counters.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port flush, input, 1, request to re-initialise the whole table.
REQ-005 The block SHALL have port pred_req, input, 1, prediction lookup request.
REQ-006 The block SHALL have port pred_idx, input, IDX_W, lookup index.
REQ-007 The block SHALL have port pred_vld, output, 1, one-cycle pulse marking a valid lookup result.
REQ-008 The block SHALL have port pred_taken, output, 1, predicted direction, equal to counter bit 1.
REQ-009 The block SHALL have port pred_cnt, output, 2, full counter value returned by the lookup.
REQ-010 The block SHALL have port upd_req, input, 1, resolved-branch update request.
REQ-011 The block SHALL have port upd_idx, input, IDX_W, update index.
REQ-012 The block SHALL have port upd_taken, input, 1, resolved direction, 1 = taken.
REQ-013 The block SHALL have port ready, output, 1, high when requests are accepted.

Function
REQ-014 The block SHALL implement a two-state FSM: READY (ready=1) and CLEAR (ready=0).
REQ-015 The block SHALL accept a lookup at a rising edge when pred_req=1, state=READY and flush=0.
REQ-016 One cycle after an accepted lookup, the block SHALL drive pred_vld=1, pred_cnt=entry[pred_idx] and pred_taken=pred_cnt[1].
REQ-017 In cycles with no accepted lookup, the block SHALL drive pred_vld=0 and hold pred_cnt and pred_taken at their last values.
REQ-018 The block SHALL sustain back-to-back lookups at one per cycle.
REQ-019 The block SHALL accept an update at a rising edge when upd_req=1, state=READY and flush=0, and write the new value at that same edge.
REQ-020 Update arithmetic SHALL saturate: with upd_taken=1, 00->01->10->11->11; with upd_taken=0, 11->10->01->00->00.
REQ-021 A lookup and an update to different indices in the same cycle SHALL proceed independently.
REQ-022 For a same-cycle lookup and update to the same index, the returned value is set by BHT_BYPASS_EN (REQ-031).
REQ-023 flush=1 in READY SHALL move the FSM to CLEAR at the next edge, with clear pointer ptr=0.
REQ-024 In CLEAR, each cycle the block SHALL write entry[ptr]=01 and increment ptr.
REQ-025 After writing entry 2^IDX_W-1, the block SHALL return to READY; ready is therefore low for exactly 2^IDX_W cycles.
REQ-026 flush SHALL take priority over requests: lookups and updates presented in a flush cycle or during CLEAR SHALL be dropped (no pred_vld, no table write).
REQ-027 flush=1 during CLEAR SHALL restart the sweep at ptr=0.
REQ-028 ptr SHALL be IDX_W bits wide and SHALL wrap to 0 on leaving CLEAR.

Reset
REQ-029 While rst=1, the block SHALL asynchronously set all entries to 01, FSM=READY, ptr=0, pred_vld=0, pred_taken=0, pred_cnt=00 and ready=1.
REQ-030 Asserting rst mid-CLEAR or while a lookup is pending SHALL abort the operation; no pred_vld pulse follows the release of reset.

Configuration
REQ-031 With BHT_BYPASS_EN defined, a same-index same-cycle lookup SHALL return the post-update (saturated) value; without it, the lookup SHALL return the pre-update value.

Verification
REQ-032 Saturation: reset, apply upd idx 3 taken x4, then lookup idx 3 -> pred_cnt=11, pred_taken=1; then not-taken x4, lookup -> pred_cnt=00, pred_taken=0.
REQ-033 Back-to-back lookups: lookup idx 0,1,2 on consecutive cycles after reset -> three consecutive pred_vld pulses, each with pred_cnt=01 and pred_taken=0.
REQ-034 Collision: entry 5=01, same-cycle upd idx 5 taken plus lookup idx 5 -> pred_cnt=01 without the macro, 10 with BHT_BYPASS_EN; entry 5=10 afterwards in both builds.
REQ-035 Flush: set entries 2=11 and 9=00, pulse flush -> ready low for exactly 16 cycles; requests during CLEAR produce no pred_vld; afterwards lookups of idx 2 and idx 9 both return 01.
REQ-036 Reset mid-CLEAR: assert rst at sweep cycle 7 -> immediately ready=1, pred_vld=0, every entry reads 01.

Source files
------------

// File: rtl/bht_ctrl.sv
// Branch history table of 2-bit saturating counters with lookup, update and a sweeping flush.
// Optional macro BHT_BYPASS_EN: a same-index, same-cycle lookup returns the post-update value.
module bht_ctrl #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             pred_req,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic [1:0]       pred_cnt,
  input  logic             upd_req,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             ready
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [1:0]  CNT_INIT = 2'b01;

  typedef enum logic {S_READY = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [DEPTH-1:0][1:0]       tbl_q, tbl_d;
  logic                        pred_vld_q, pred_vld_d;
  logic                        pred_taken_q, pred_taken_d;
  logic [1:0]                  pred_cnt_q, pred_cnt_d;
  logic                        ready_q, ready_d;

  logic                        lkp_acc, upd_acc;
  logic [1:0]                  upd_cur, upd_new, rd_val;

  assign lkp_acc = pred_req && (state_q == S_READY) && !flush;
  assign upd_acc = upd_req  && (state_q == S_READY) && !flush;

  // Saturating counter step for the entry being updated
  always_comb begin
    upd_cur = tbl_q[upd_idx];
    upd_new = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_new = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_new = upd_cur - 2'd1;
    end
  end

  always_comb begin
    rd_val = tbl_q[pred_idx];
`ifdef BHT_BYPASS_EN
    if (upd_acc && (upd_idx == pred_idx)) rd_val = upd_new;
`endif
  end

  always_comb begin
    tbl_d = tbl_q;
    if (state_q == S_CLEAR) tbl_d[ptr_q] = CNT_INIT;
    else if (upd_acc)       tbl_d[upd_idx] = upd_new;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state; flush restarts the sweep from entry 0
  always_comb begin
    state_d = state_q;
    ptr_d   = '0;
    case (state_q)
      S_READY: begin
        if (flush) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (flush) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
        end
      end
      default: state_d = S_READY;
    endcase
  end

  // FSM outputs and lookup result
  always_comb begin
    ready_d      = (state_d == S_READY);
    pred_vld_d   = lkp_acc;
    pred_cnt_d   = pred_cnt_q;
    pred_taken_d = pred_taken_q;
    if (lkp_acc) begin
      pred_cnt_d   = rd_val;
      pred_taken_d = rd_val[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_q        <= {DEPTH{CNT_INIT}};
      pred_vld_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_cnt_q   <= 2'b00;
      ready_q      <= 1'b1;
    end else begin
      tbl_q        <= tbl_d;
      pred_vld_q   <= pred_vld_d;
      pred_taken_q <= pred_taken_d;
      pred_cnt_q   <= pred_cnt_d;
      ready_q      <= ready_d;
    end
  end

  assign pred_vld   = pred_vld_q;
  assign pred_taken = pred_taken_q;
  assign pred_cnt   = pred_cnt_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: directed scenarios plus random traffic against a table model.
module tb_bht_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       pred_req = 1'b0;
  logic [3:0] pred_idx = '0;
  logic       pred_vld;
  logic       pred_taken;
  logic [1:0] pred_cnt;
  logic       upd_req = 1'b0;
  logic [3:0] upd_idx = '0;
  logic       upd_taken = 1'b0;
  logic       ready;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  bht_ctrl #(.IDX_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pred_req(pred_req), .pred_idx(pred_idx),
    .pred_vld(pred_vld), .pred_taken(pred_taken), .pred_cnt(pred_cnt),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a flush re-initialises the table at once and blocks requests for 16 cycles
  int m_tbl [DEPTH];
  int m_clr;
  int m_vld;
  int m_cnt;

  always @(posedge clk or posedge rst) begin
    int old_v, cur;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
      m_clr = 0; m_vld = 0; m_cnt = 0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
      m_clr = DEPTH; m_vld = 0;
    end else if (m_clr > 0) begin
      m_clr--; m_vld = 0;
    end else begin
      old_v = m_tbl[int'(pred_idx)];
      if (upd_req) begin
        cur = m_tbl[int'(upd_idx)];
        m_tbl[int'(upd_idx)] = upd_taken ? ((cur < 3) ? cur + 1 : 3) : ((cur > 0) ? cur - 1 : 0);
      end
      if (pred_req) begin
        m_vld = 1;
`ifdef BHT_BYPASS_EN
        m_cnt = m_tbl[int'(pred_idx)];
`else
        m_cnt = old_v;
`endif
      end else begin
        m_vld = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", int'(ready), (m_clr == 0) ? 1 : 0);
      chk("pred_vld", int'(pred_vld), m_vld);
      chk("pred_cnt", int'(pred_cnt), m_cnt);
      chk("pred_taken", int'(pred_taken), m_cnt / 2);
    end
  end

  task automatic step(input bit fl, input bit pr, input int pi, input bit ur, input int ui, input bit ut);
    flush = fl; pred_req = pr; pred_idx = 4'(pi);
    upd_req = ur; upd_idx = 4'(ui); upd_taken = ut;
    @(posedge clk); #2;
    flush = 1'b0; pred_req = 1'b0; upd_req = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic lookup_chk(input int idx, input int exp_cnt, input string name);
    step(0, 1, idx, 0, 0, 0);
    chk({name, "_vld"}, int'(pred_vld), 1);
    chk({name, "_cnt"}, int'(pred_cnt), exp_cnt);
    chk({name, "_taken"}, int'(pred_taken), exp_cnt / 2);
  endtask

  initial begin
    int n_low;
    bit fl;
    @(posedge clk); #2;
    chk("rst_ready", int'(ready), 1);
    chk("rst_vld", int'(pred_vld), 0);
    chk("rst_cnt", int'(pred_cnt), 0);
    chk("rst_taken", int'(pred_taken), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Saturation up then down
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3, 1);
    lookup_chk(3, 3, "sat_up");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 3, 0);
    lookup_chk(3, 0, "sat_dn");

    // Back-to-back lookups after reset
    do_reset();
    for (int i = 0; i < 3; i++) lookup_chk(i, 1, "b2b");
    idle();
    chk("hold_vld", int'(pred_vld), 0);
    chk("hold_cnt", int'(pred_cnt), 1);

    // Same-index collision
    do_reset();
    step(0, 1, 5, 1, 5, 1);
`ifdef BHT_BYPASS_EN
    chk("coll_cnt", int'(pred_cnt), 2);
`else
    chk("coll_cnt", int'(pred_cnt), 1);
`endif
    lookup_chk(5, 2, "coll_after");

    // Flush sweep with requests held off
    step(0, 0, 0, 1, 2, 1);
    step(0, 0, 0, 1, 2, 1);
    step(0, 0, 0, 1, 9, 0);
    lookup_chk(2, 3, "pre_flush2");
    lookup_chk(9, 0, "pre_flush9");
    step(1, 1, 2, 1, 2, 1);
    chk("flush_vld", int'(pred_vld), 0);
    n_low = (ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 40 && ready == 1'b0; i++) begin
      step(0, 1, i % 16, 1, 9, 1);
      chk("clear_vld", int'(pred_vld), 0);
      if (ready == 1'b0) n_low++;
    end
    chk("clear_len", n_low, 16);
    lookup_chk(2, 1, "post_flush2");
    lookup_chk(9, 1, "post_flush9");

    // Reset during a pending lookup pulse
    step(0, 1, 4, 0, 0, 0);
    rst = 1'b1; #1;
    chk("rst_lkp_vld", int'(pred_vld), 0);
    chk("rst_lkp_cnt", int'(pred_cnt), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Reset mid-sweep
    step(0, 0, 0, 1, 7, 1);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) idle();
    chk("mid_clear_ready", int'(ready), 0);
    rst = 1'b1; #1;
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_vld", int'(pred_vld), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle();
    chk("post_rst_vld", int'(pred_vld), 0);
    for (int i = 0; i < DEPTH; i++) lookup_chk(i, 1, "post_rst_all");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        fl = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 1) == 1)
          step(fl, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
        else
          step(fl, 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
               int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
